pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
//  Pipeline controller that drives the hold/flush inputs of the if_id and id_ex pipe registers, and the PC redirect.
//  Resolves three hazards:
//   - EX jump/branch: flush, redirect PC.
//   - ID load-use: one bubble.
//   - EX multi-cycle op: freeze front end, with a watchdog.
//  Flushed stages reload their reset values (id_ex inst = NOP 32'h00000013).
// PARAMETERS
//  XLEN      32  PC/address width
//  BUSY_MAX  64  max cycles in BUSY before the watchdog fires (>=2)
//  CNT_W     32  perf counter width (PIPE_CTRL_PERF_EN only)
// PORTS
//  clk            in   1     rising-edge clock
//  rst            in   1     synchronous, active-high reset
//  jump_en_i      in   1     EX resolved a taken jump/branch this cycle
//  jump_addr_i    in   XLEN  target for jump_en_i
//  load_use_i     in   1     ID inst reads rd of a load now in EX
//  ex_busy_i      in   1     EX multi-cycle unit started/is running
//  ex_done_i      in   1     EX multi-cycle unit result valid this cycle
//  hold_pc_o      out  1     PC keeps its value
//  hold_if_id_o   out  1     if_id keeps its contents
//  hold_id_ex_o   out  1     id_ex keeps its contents
//  flush_if_id_o  out  1     if_id loads reset values next edge
//  flush_id_ex_o  out  1     id_ex loads reset values (NOP) next edge
//  jump_en_o      out  1     PC loads jump_addr_o next edge
//  jump_addr_o    out  XLEN  redirect target
//  timeout_o      out  1     sticky: BUSY watchdog expired
//  stall_cnt_o    out  CNT_W cycles with hold_pc_o=1 (PIPE_CTRL_PERF_EN)
//  flush_cnt_o    out  CNT_W cycles with flush_id_ex_o=1 (PIPE_CTRL_PERF_EN)
// BEHAVIOUR
//  State: registered FSM {RUN, BUSY}, busy_cnt[$clog2(BUSY_MAX+1)-1:0], timeout flag.
//  Hold/flush/jump outputs: combinational from state + inputs; act on the same edge.
//  rst=1: state<=RUN, busy_cnt<=0, timeout_o<=0, perf counters<=0.
//  rst=1 also forces all hold/flush/jump outputs to 0 and jump_addr_o to 0.
//  RUN, priority jump > busy > load_use:
//   - jump_en_i: jump_en_o=1, jump_addr_o=jump_addr_i, flush_if_id_o=1, flush_id_ex_o=1, holds=0; stay RUN.
//     Jump wins over a simultaneous load_use_i or ex_busy_i (the younger insts die).
//   - ex_busy_i & !ex_done_i: hold_pc_o=hold_if_id_o=hold_id_ex_o=1; busy_cnt<=1; ->BUSY.
//   - ex_busy_i & ex_done_i (1-cycle op): no hold; stay RUN.
//   - load_use_i: hold_pc_o=hold_if_id_o=1, flush_id_ex_o=1 (one bubble); stay RUN.
//     Re-evaluated each cycle, so it self-clears once the load leaves EX.
//   - none: all outputs 0.
//  BUSY:
//   - All three holds=1 while !ex_done_i; busy_cnt increments.
//   - ex_done_i: holds=0 that cycle; ->RUN; busy_cnt<=0.
//   - jump_en_i and load_use_i are ignored in BUSY.
//   - busy_cnt==BUSY_MAX & !ex_done_i (watchdog):
//     timeout_o<=1 (sticky to rst); holds=0; flush_id_ex_o=1; ->RUN; busy_cnt<=0.
//   - ex_done_i in the watchdog cycle wins: normal exit, no timeout.
//  hold_* and flush_* are never both 1 for the same register.
//  Perf counters wrap at 2^CNT_W.
// CONFIGURATION
//  PIPE_CTRL_PERF_EN defined:
//   stall_cnt_o/flush_cnt_o ports exist; increment per cycle while hold_pc_o / flush_id_ex_o = 1.
//  PIPE_CTRL_PERF_EN undefined:
//   ports and counters absent; all other behaviour identical.
// TESTING
//  1 jump_en_i=1, jump_addr_i=32'h0000_0100, 1 cycle
//    -> same cycle jump_en_o=1, addr=0x100, both flushes=1; next cycle all 0.
//  2 load_use_i=1 for 1 cycle
//    -> hold_pc_o=hold_if_id_o=1, flush_id_ex_o=1, hold_id_ex_o=0; id_ex inst_o=0x13 next edge.
//  3 ex_busy_i=1 then ex_done_i=1 after 5 cycles
//    -> holds=1 for exactly 5 cycles, 0 in the done cycle, state RUN.
//  4 ex_busy_i=1, ex_done_i never (BUSY_MAX=64)
//    -> watchdog cycle: timeout_o=1 next edge, flush_id_ex_o=1, holds drop; timeout_o stays 1 until rst.
//  5 jump_en_i, load_use_i, ex_busy_i all 1 in RUN
//    -> jump response only, no hold, stays RUN.
//  6 rst=1 asserted in BUSY cycle 3
//    -> next edge RUN, all outputs 0, timeout_o=0; with PIPE_CTRL_PERF_EN counters=0.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and hold/flush/redirect outputs of the pipeline controller.
// PIPE_CTRL_PERF_EN adds the stall/flush performance counter signals.
interface pipe_ctrl_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);
  logic            jump_en_i;
  logic [XLEN-1:0] jump_addr_i;
  logic            load_use_i;
  logic            ex_busy_i;
  logic            ex_done_i;
  logic            hold_pc_o;
  logic            hold_if_id_o;
  logic            hold_id_ex_o;
  logic            flush_if_id_o;
  logic            flush_id_ex_o;
  logic            jump_en_o;
  logic [XLEN-1:0] jump_addr_o;
  logic            timeout_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
`else
  logic [CNT_W-1:0] unused_perf;
  assign unused_perf = '0;
`endif

  // master: the controller; slave: the pipeline that obeys it
  modport master (
    input  jump_en_i, jump_addr_i, load_use_i, ex_busy_i, ex_done_i,
    output hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o,
    output jump_en_o, jump_addr_o, timeout_o
`ifdef PIPE_CTRL_PERF_EN
    , output stall_cnt_o, flush_cnt_o
`endif
  );

  modport slave (
    output jump_en_i, jump_addr_i, load_use_i, ex_busy_i, ex_done_i,
    input  hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o,
    input  jump_en_o, jump_addr_o, timeout_o
`ifdef PIPE_CTRL_PERF_EN
    , input stall_cnt_o, flush_cnt_o
`endif
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: jump flush/redirect, load-use bubble, multi-cycle freeze
// with watchdog. Optional perf counters enabled by PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned BUSY_MAX = 64,
  parameter int unsigned CNT_W    = 32
) (
  input logic         clk,
  input logic         rst,
  pipe_ctrl_if.master bus
);
  localparam int unsigned BcW = $clog2(BUSY_MAX + 1);

  typedef enum logic [0:0] {StRun, StBusy} state_e;

  state_e          state_q, state_d;
  logic [BcW-1:0]  busy_cnt_q, busy_cnt_d;
  logic            timeout_q, timeout_d;

  logic            hold_pc, hold_if_id, hold_id_ex;
  logic            flush_if_id, flush_id_ex;
  logic            jump_en;
  logic [XLEN-1:0] jump_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      busy_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_cnt_q <= busy_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    busy_cnt_d  = busy_cnt_q;
    timeout_d   = timeout_q;
    hold_pc     = 1'b0;
    hold_if_id  = 1'b0;
    hold_id_ex  = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    jump_en     = 1'b0;
    jump_addr   = '0;
    if (!rst) begin
      unique case (state_q)
        StRun: begin
          if (bus.jump_en_i) begin
            // younger instructions die, so a jump overrides any stall request
            jump_en     = 1'b1;
            jump_addr   = bus.jump_addr_i;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (bus.ex_busy_i) begin
            if (!bus.ex_done_i) begin
              hold_pc    = 1'b1;
              hold_if_id = 1'b1;
              hold_id_ex = 1'b1;
              busy_cnt_d = BcW'(1);
              state_d    = StBusy;
            end
          end else if (bus.load_use_i) begin
            hold_pc     = 1'b1;
            hold_if_id  = 1'b1;
            flush_id_ex = 1'b1;
          end
        end
        StBusy: begin
          if (bus.ex_done_i) begin
            busy_cnt_d = '0;
            state_d    = StRun;
          end else if (busy_cnt_q == BcW'(BUSY_MAX)) begin
            // watchdog: abandon the stuck op and bubble id_ex
            timeout_d   = 1'b1;
            flush_id_ex = 1'b1;
            busy_cnt_d  = '0;
            state_d     = StRun;
          end else begin
            hold_pc    = 1'b1;
            hold_if_id = 1'b1;
            hold_id_ex = 1'b1;
            busy_cnt_d = busy_cnt_q + BcW'(1);
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  assign bus.hold_pc_o     = hold_pc;
  assign bus.hold_if_id_o  = hold_if_id;
  assign bus.hold_id_ex_o  = hold_id_ex;
  assign bus.flush_if_id_o = flush_if_id;
  assign bus.flush_id_ex_o = flush_id_ex;
  assign bus.jump_en_o     = jump_en;
  assign bus.jump_addr_o   = jump_addr;
  assign bus.timeout_o     = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hold_pc)     stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_id_ex) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.flush_cnt_o = flush_cnt_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif
endmodule
